pkt_fifo: RTL and testbench



---
 rtl/pkt_fifo_pkg.sv | 8 +
 rtl/pkt_fifo_mem.sv | 20 ++
 rtl/pkt_fifo.sv | 179 +++++++++++++++++
 tb/tb_pkt_fifo.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_fifo_pkg.sv
// Shared sizing constants and write-side state type for the ingress packet queue.
package packet_pkg;
    localparam int DATA_WIDTH = 16;
    localparam int DEPTH      = 8;
    localparam int HDR_WIDTH  = 8;

    typedef enum logic [1:0] {W_IDLE, W_PKT, W_DROP} wr_state_t;
endpackage

// File: rtl/pkt_fifo_mem.sv
// Storage array for pkt_fifo: synchronous write, asynchronous read.
module pkt_fifo_mem #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/pkt_fifo.sv
// Packet-aware ingress queue: store-and-forward commit, atomic discard by rewinding
// the write pointer to the last committed position.
module pkt_fifo #(
    parameter int DATA_WIDTH   = packet_pkg::DATA_WIDTH,
    parameter int DEPTH        = packet_pkg::DEPTH,
    parameter int AFULL_THRESH = DEPTH - 2,
    parameter int PKT_MODE     = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [DATA_WIDTH-1:0]             wr_data,
    input  logic                              wr_en,
    input  logic                              wr_sop,
    input  logic                              wr_eop,
    output logic                              wr_full,
    output logic                              wr_afull,
    output logic                              wr_drop,
    output logic [15:0]                       drop_count,
    input  logic                              rd_en,
    output logic [DATA_WIDTH-1:0]             rd_data,
    output logic                              rd_valid,
    output logic                              rd_sop,
    output logic                              rd_eop,
    output logic                              empty,
    output logic [packet_pkg::HDR_WIDTH-1:0]  header_out,
    output logic [$clog2(DEPTH):0]            pkt_count
);
    import packet_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int MW = DATA_WIDTH + 2;
    localparam logic [PW-1:0] ONE       = PW'(1);
    localparam logic [PW-1:0] FULL_LVL  = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, pkt_count_q, pkt_count_d;
    logic [PW-1:0] occupancy, readable, base_ptr;
    wr_state_t     state_q, state_d;
    logic          mem_we, commit_ev, drop_ev, rd_fire, eop_read;
    logic [MW-1:0] mem_wdata, mem_rdata;
    logic [15:0]   drop_count_q, drop_count_d;
    logic          wr_drop_q;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d, rd_sop_q, rd_sop_d, rd_eop_q, rd_eop_d;

    assign occupancy  = wr_ptr_q - rd_ptr_q;
    assign readable   = commit_ptr_q - rd_ptr_q;
    assign empty      = (readable == '0);
    assign wr_full    = (occupancy == FULL_LVL);
    assign wr_afull   = (occupancy >= AFULL_LVL);
    assign mem_wdata  = {wr_eop, wr_sop, wr_data};
    assign header_out = empty ? '0 : mem_rdata[DATA_WIDTH-1 -: HDR_WIDTH];

    pkt_fifo_mem #(.WIDTH(MW), .DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (base_ptr[AW-1:0]),
        .wdata (mem_wdata),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (mem_rdata)
    );

    // A new sop inside an open packet rewinds first, so the word is placed and
    // full-checked against the committed pointer rather than the stale write pointer.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        state_d      = state_q;
        base_ptr     = wr_ptr_q;
        mem_we       = 1'b0;
        commit_ev    = 1'b0;
        drop_ev      = 1'b0;
        if (PKT_MODE == 0) begin
            if (wr_en && !wr_full) begin
                mem_we       = 1'b1;
                wr_ptr_d     = wr_ptr_q + ONE;
                commit_ptr_d = wr_ptr_q + ONE;
            end else if (wr_en) begin
                drop_ev = 1'b1;
            end
        end else if (wr_en) begin
            if (wr_sop) begin
                if (state_q == W_PKT) begin
                    base_ptr = commit_ptr_q;
                    wr_ptr_d = commit_ptr_q;
                    drop_ev  = 1'b1;
                end
                if ((base_ptr - rd_ptr_q) == FULL_LVL) begin
                    drop_ev = 1'b1;
                    state_d = wr_eop ? W_IDLE : W_DROP;
                end else begin
                    mem_we   = 1'b1;
                    wr_ptr_d = base_ptr + ONE;
                    if (wr_eop) begin
                        commit_ptr_d = base_ptr + ONE;
                        commit_ev    = 1'b1;
                        state_d      = W_IDLE;
                    end else begin
                        state_d = W_PKT;
                    end
                end
            end else begin
                unique case (state_q)
                    W_IDLE: drop_ev = 1'b1;
                    W_PKT: begin
                        if (wr_full) begin
                            wr_ptr_d = commit_ptr_q;
                            drop_ev  = 1'b1;
                            state_d  = wr_eop ? W_IDLE : W_DROP;
                        end else begin
                            mem_we   = 1'b1;
                            wr_ptr_d = wr_ptr_q + ONE;
                            if (wr_eop) begin
                                commit_ptr_d = wr_ptr_q + ONE;
                                commit_ev    = 1'b1;
                                state_d      = W_IDLE;
                            end
                        end
                    end
                    W_DROP: if (wr_eop) state_d = W_IDLE;
                    default: state_d = W_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        rd_fire    = rd_en && !empty;
        eop_read   = rd_fire && mem_rdata[MW-1] && (PKT_MODE != 0);
        rd_ptr_d   = rd_fire ? rd_ptr_q + ONE : rd_ptr_q;
        rd_data_d  = rd_fire ? mem_rdata[DATA_WIDTH-1:0] : rd_data_q;
        rd_sop_d   = rd_fire ? mem_rdata[DATA_WIDTH] : rd_sop_q;
        rd_eop_d   = rd_fire ? mem_rdata[MW-1] : rd_eop_q;
        rd_valid_d = rd_fire;
        pkt_count_d = pkt_count_q;
        if (commit_ev && !eop_read)      pkt_count_d = pkt_count_q + ONE;
        else if (!commit_ev && eop_read) pkt_count_d = pkt_count_q - ONE;
        drop_count_d = (drop_ev && drop_count_q != 16'hFFFF) ? drop_count_q + 16'd1
                                                               : drop_count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            pkt_count_q  <= '0;
            state_q      <= W_IDLE;
            drop_count_q <= '0;
            wr_drop_q    <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            rd_sop_q     <= 1'b0;
            rd_eop_q     <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            pkt_count_q  <= pkt_count_d;
            state_q      <= state_d;
            drop_count_q <= drop_count_d;
            wr_drop_q    <= drop_ev;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            rd_sop_q     <= rd_sop_d;
            rd_eop_q     <= rd_eop_d;
        end
    end

    assign wr_drop    = wr_drop_q;
    assign drop_count = drop_count_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign rd_sop     = rd_sop_q;
    assign rd_eop     = rd_eop_q;
    assign pkt_count  = pkt_count_q;
endmodule

// File: tb/tb_pkt_fifo.sv
// Bench for pkt_fifo: directed vectors and sequences plus a queue-based random reference.
module tb_pkt_fifo;
    localparam int DEP = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] wr_data = '0;
    logic        wr_en = 1'b0, wr_sop = 1'b0, wr_eop = 1'b0, rd_en = 1'b0;
    logic        wr_full, wr_afull, wr_drop, rd_valid, rd_sop, rd_eop, empty;
    logic [15:0] drop_count, rd_data;
    logic [7:0]  header_out;
    logic [3:0]  pkt_count;

    logic [15:0] w0_data = '0;
    logic        w0_en = 1'b0, w0_rd = 1'b0;
    logic        w0_full, w0_afull, w0_drop, w0_rvalid, w0_rsop, w0_reop, w0_empty;
    logic [15:0] w0_dcnt, w0_rdata;
    logic [7:0]  w0_hdr;
    logic [3:0]  w0_pkt;

    pkt_fifo #(.DATA_WIDTH(16), .DEPTH(DEP), .AFULL_THRESH(DEP-2), .PKT_MODE(1)) u_pkt (
        .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_en(wr_en), .wr_sop(wr_sop),
        .wr_eop(wr_eop), .wr_full(wr_full), .wr_afull(wr_afull), .wr_drop(wr_drop),
        .drop_count(drop_count), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_sop(rd_sop), .rd_eop(rd_eop), .empty(empty), .header_out(header_out),
        .pkt_count(pkt_count)
    );

    pkt_fifo #(.DATA_WIDTH(16), .DEPTH(DEP), .AFULL_THRESH(DEP-2), .PKT_MODE(0)) u_word (
        .clk(clk), .rst_n(rst_n), .wr_data(w0_data), .wr_en(w0_en), .wr_sop(1'b0),
        .wr_eop(1'b0), .wr_full(w0_full), .wr_afull(w0_afull), .wr_drop(w0_drop),
        .drop_count(w0_dcnt), .rd_en(w0_rd), .rd_data(w0_rdata), .rd_valid(w0_rvalid),
        .rd_sop(w0_rsop), .rd_eop(w0_reop), .empty(w0_empty), .header_out(w0_hdr),
        .pkt_count(w0_pkt)
    );

    int unsigned n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic cyc(input logic en, input logic s, input logic e,
                       input logic [15:0] d, input logic r);
        wr_en = en; wr_sop = s; wr_eop = e; wr_data = d; rd_en = r;
        @(posedge clk); #1;
        wr_en = 1'b0; wr_sop = 1'b0; wr_eop = 1'b0; rd_en = 1'b0;
    endtask

    task automatic cyc0(input logic en, input logic [15:0] d, input logic r);
        w0_en = en; w0_data = d; w0_rd = r;
        @(posedge clk); #1;
        w0_en = 1'b0; w0_rd = 1'b0;
    endtask

    typedef struct {
        logic wen, sop, eop; logic [15:0] data; logic ren;
        logic e_empty; logic [3:0] e_pkt; logic [7:0] e_hdr;
        logic e_rv; logic [15:0] e_rd; logic e_rsop, e_reop;
    } vec_t;

    function automatic vec_t mk(input logic wen, input logic sop, input logic eop,
                                input logic [15:0] d, input logic ren, input logic ee,
                                input logic [3:0] ep, input logic [7:0] eh, input logic erv,
                                input logic [15:0] erd, input logic ers, input logic ere);
        vec_t v;
        v.wen = wen; v.sop = sop; v.eop = eop; v.data = d; v.ren = ren;
        v.e_empty = ee; v.e_pkt = ep; v.e_hdr = eh; v.e_rv = erv;
        v.e_rd = erd; v.e_rsop = ers; v.e_reop = ere;
        return v;
    endfunction

    // Reference: committed words, the open packet, and a skip-until-eop flag.
    logic [17:0] cq[$];
    logic [17:0] pq[$];
    bit          skip;
    int unsigned dcnt;

    function automatic int unsigned eops_in_cq();
        int unsigned n = 0;
        foreach (cq[i]) if (cq[i][17]) n++;
        return n;
    endfunction

    task automatic commit_pq();
        foreach (pq[i]) cq.push_back(pq[i]);
        pq.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[8];
        logic [17:0] w, erd;
        bit drop, ev, s, e, en, r;
        logic [15:0] d;
        int unsigned occ;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", wr_full, 1'b0);
        chk("rst_afull", wr_afull, 1'b0);
        chk("rst_hdr", header_out, 8'h00);
        chk("rst_pkt", pkt_count, 4'd0);
        chk("rst_dcnt", drop_count, 16'd0);
        chk("rst_rvalid", rd_valid, 1'b0);
        chk("rst_rdata", rd_data, 16'h0000);
        chk("rst_wdrop", wr_drop, 1'b0);

        // Reset mid-packet with a committed packet and a drop already recorded
        cyc(1'b1, 1'b1, 1'b1, 16'h9900, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 16'h9901, 1'b0);
        chk("nosop_drop", wr_drop, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 16'h1111, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 16'h2222, 1'b0);
        chk("pre_rst_empty", empty, 1'b0);
        chk("pre_rst_pkt", pkt_count, 4'd1);
        chk("pre_rst_dcnt", drop_count, 16'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_empty", empty, 1'b1);
        chk("mid_rst_pkt", pkt_count, 4'd0);
        chk("mid_rst_dcnt", drop_count, 16'd0);
        chk("mid_rst_hdr", header_out, 8'h00);
        @(posedge clk); #1 rst_n = 1'b1;
        cyc(1'b1, 1'b1, 1'b1, 16'h5555, 1'b0);
        chk("post_rst_empty", empty, 1'b0);
        chk("post_rst_hdr", header_out, 8'h55);
        chk("post_rst_pkt", pkt_count, 4'd1);
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        chk("post_rst_rd", rd_data, 16'h5555);
        chk("post_rst_rsop", rd_sop, 1'b1);
        chk("post_rst_reop", rd_eop, 1'b1);
        chk("post_rst_empty2", empty, 1'b1);

        // Three-word packet, table driven
        tbl[0] = mk(1'b1,1'b1,1'b0,16'hA101,1'b0, 1'b1,4'd0,8'h00,1'b0,16'h0,1'b0,1'b0);
        tbl[1] = mk(1'b1,1'b0,1'b0,16'hA202,1'b0, 1'b1,4'd0,8'h00,1'b0,16'h0,1'b0,1'b0);
        tbl[2] = mk(1'b1,1'b0,1'b1,16'hA303,1'b0, 1'b0,4'd1,8'hA1,1'b0,16'h0,1'b0,1'b0);
        tbl[3] = mk(1'b0,1'b0,1'b0,16'h0,1'b1, 1'b0,4'd1,8'hA2,1'b1,16'hA101,1'b1,1'b0);
        tbl[4] = mk(1'b0,1'b0,1'b0,16'h0,1'b1, 1'b0,4'd1,8'hA3,1'b1,16'hA202,1'b0,1'b0);
        tbl[5] = mk(1'b0,1'b0,1'b0,16'h0,1'b1, 1'b1,4'd0,8'h00,1'b1,16'hA303,1'b0,1'b1);
        tbl[6] = mk(1'b0,1'b0,1'b0,16'h0,1'b1, 1'b1,4'd0,8'h00,1'b0,16'h0,1'b0,1'b0);
        tbl[7] = mk(1'b0,1'b0,1'b0,16'h0,1'b0, 1'b1,4'd0,8'h00,1'b0,16'h0,1'b0,1'b0);
        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].wen, tbl[i].sop, tbl[i].eop, tbl[i].data, tbl[i].ren);
            chk($sformatf("v%0d_empty", i), empty, tbl[i].e_empty);
            chk($sformatf("v%0d_pkt", i), pkt_count, tbl[i].e_pkt);
            chk($sformatf("v%0d_hdr", i), header_out, tbl[i].e_hdr);
            chk($sformatf("v%0d_rvalid", i), rd_valid, tbl[i].e_rv);
            if (tbl[i].e_rv) begin
                chk($sformatf("v%0d_rdata", i), rd_data, tbl[i].e_rd);
                chk($sformatf("v%0d_rsop", i), rd_sop, tbl[i].e_rsop);
                chk($sformatf("v%0d_reop", i), rd_eop, tbl[i].e_reop);
            end
        end

        // Overflowing packet behind a committed one
        cyc(1'b1, 1'b1, 1'b0, 16'h3100, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 16'h3200, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 16'h3300, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 16'h6100, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 16'h6200, 1'b0);
        chk("afull_5", wr_afull, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 16'h6300, 1'b0);
        chk("afull_6", wr_afull, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 16'h6400, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 16'h6500, 1'b0);
        chk("full_8", wr_full, 1'b1);
        chk("full_8_pkt", pkt_count, 4'd1);
        cyc(1'b1, 1'b0, 1'b0, 16'h6600, 1'b0);
        chk("ovf_wdrop", wr_drop, 1'b1);
        chk("ovf_dcnt", drop_count, 16'd1);
        chk("ovf_full", wr_full, 1'b0);
        chk("ovf_afull", wr_afull, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 16'h6700, 1'b0);
        chk("ovf_tail_wdrop", wr_drop, 1'b0);
        chk("ovf_tail_dcnt", drop_count, 16'd1);
        chk("ovf_tail_pkt", pkt_count, 4'd1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
            chk($sformatf("ovf_rd%0d", i), rd_data, 16'h3100 + 16'(i) * 16'h0100);
            chk($sformatf("ovf_reop%0d", i), rd_eop, (i == 2) ? 1'b1 : 1'b0);
        end
        chk("ovf_empty", empty, 1'b1);

        // Unterminated packet superseded by a new sop
        cyc(1'b1, 1'b1, 1'b0, 16'hB100, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 16'hB200, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 16'hC100, 1'b0);
        chk("bc_wdrop", wr_drop, 1'b1);
        chk("bc_dcnt", drop_count, 16'd2);
        chk("bc_empty1", empty, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 16'hC200, 1'b0);
        chk("bc_empty2", empty, 1'b0);
        chk("bc_hdr", header_out, 8'hC1);
        chk("bc_pkt", pkt_count, 4'd1);
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        chk("bc_rd0", rd_data, 16'hC100);
        chk("bc_rsop0", rd_sop, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        chk("bc_rd1", rd_data, 16'hC200);
        chk("bc_reop1", rd_eop, 1'b1);
        chk("bc_empty3", empty, 1'b1);

        // Eop read coinciding with the next commit
        cyc(1'b1, 1'b1, 1'b0, 16'hD100, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 16'hD200, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 16'hE100, 1'b1);
        chk("sim_rd0", rd_data, 16'hD100);
        chk("sim_pkt0", pkt_count, 4'd1);
        cyc(1'b1, 1'b0, 1'b1, 16'hE200, 1'b1);
        chk("sim_rd1", rd_data, 16'hD200);
        chk("sim_reop1", rd_eop, 1'b1);
        chk("sim_pkt1", pkt_count, 4'd1);
        chk("sim_hdr", header_out, 8'hE1);
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        chk("sim_rd2", rd_data, 16'hE100);
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        chk("sim_rd3", rd_data, 16'hE200);
        chk("sim_pkt3", pkt_count, 4'd0);
        chk("sim_empty", empty, 1'b1);

        // Plain word FIFO
        cyc0(1'b1, 16'h7101, 1'b0);
        chk("w0_empty", w0_empty, 1'b0);
        chk("w0_hdr", w0_hdr, 8'h71);
        for (int k = 1; k < 8; k++) cyc0(1'b1, 16'h7101 + 16'(k) * 16'h0101, 1'b0);
        chk("w0_full", w0_full, 1'b1);
        chk("w0_pkt", w0_pkt, 4'd0);
        cyc0(1'b1, 16'h7909, 1'b0);
        chk("w0_wdrop", w0_drop, 1'b1);
        chk("w0_dcnt", w0_dcnt, 16'd1);
        for (int k = 0; k < 8; k++) begin
            cyc0(1'b0, 16'h0, 1'b1);
            chk($sformatf("w0_rd%0d", k), w0_rdata, 16'h7101 + 16'(k) * 16'h0101);
        end
        chk("w0_empty_end", w0_empty, 1'b1);

        // Randomised run against the queue model
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        cq.delete(); pq.delete(); skip = 0; dcnt = 0;
        for (int c = 0; c < 3000; c++) begin
            en = ($urandom_range(0, 9) < 6);
            s  = ($urandom_range(0, 4) == 0);
            e  = ($urandom_range(0, 3) == 0);
            d  = 16'($urandom);
            r  = ($urandom_range(0, 2) != 0);
            occ = cq.size() + pq.size();
            ev = (cq.size() != 0) && r;
            drop = 0;
            if (en) begin
                w = {e, s, d};
                if (s) begin
                    if (pq.size() != 0) begin drop = 1; pq.delete(); end
                    skip = 0;
                    if (cq.size() >= DEP) begin drop = 1; skip = !e; end
                    else begin pq.push_back(w); if (e) commit_pq(); end
                end else if (skip) begin
                    if (e) skip = 0;
                end else if (pq.size() == 0) begin
                    drop = 1;
                end else if (occ >= DEP) begin
                    drop = 1; pq.delete(); skip = !e;
                end else begin
                    pq.push_back(w);
                    if (e) commit_pq();
                end
            end
            erd = '0;
            if (ev) erd = cq.pop_front();
            if (drop && dcnt < 65535) dcnt++;
            cyc(en, s, e, d, r);
            chk("rnd_empty", empty, (cq.size() == 0));
            chk("rnd_full", wr_full, (cq.size() + pq.size() == DEP));
            chk("rnd_afull", wr_afull, (cq.size() + pq.size() >= DEP - 2));
            chk("rnd_pkt", pkt_count, eops_in_cq());
            chk("rnd_hdr", header_out, (cq.size() != 0) ? cq[0][15:8] : 8'h00);
            chk("rnd_rvalid", rd_valid, ev);
            if (ev) begin
                chk("rnd_rdata", rd_data, erd[15:0]);
                chk("rnd_rsop", rd_sop, erd[16]);
                chk("rnd_reop", rd_eop, erd[17]);
            end
            chk("rnd_wdrop", wr_drop, drop);
            chk("rnd_dcnt", drop_count, dcnt);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
